multicycle_riscv: RTL and testbench
===================================

MULTICYCLE_RISCV -- requirements
Module: multicycle_riscv

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 bit, rising-edge clock; rst input 1 bit, synchronous active-low reset.
REQ-002 Parameter XLEN, default 32, SHALL set the datapath, register and bus width; legal values are 32 and 64.
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC value loaded at reset.
REQ-004 Port mem_req SHALL be an output, 1 bit: memory transaction request.
REQ-005 Port mem_we SHALL be an output, 1 bit: 1 = store, 0 = fetch or load.
REQ-006 Port mem_addr SHALL be an output, XLEN bits: byte address, always word-aligned.
REQ-007 Port mem_wdata SHALL be an output, XLEN bits: store data.
REQ-008 Port mem_rdata SHALL be an input, XLEN bits: read data, valid when mem_req && mem_ready.
REQ-009 Port mem_ready SHALL be an input, 1 bit: transaction completes in the cycle where mem_req && mem_ready.
REQ-010 Port writedata SHALL be an output, XLEN bits: register write-back value.
REQ-011 Port wb_valid SHALL be an output, 1 bit: register write this cycle.
REQ-012 Port wb_rd SHALL be an output, 5 bits: destination register of the write-back.
REQ-013 Port retire SHALL be an output, 1 bit: one-cycle pulse when an instruction completes.
REQ-014 Port trap SHALL be an output, 1 bit: sticky flag, illegal instruction seen.

Function
REQ-015 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and TRAP; one state per cycle unless a memory stall holds the state.
REQ-016 In FETCH the block SHALL drive mem_req=1, mem_we=0 and mem_addr=pc, and hold them until mem_ready; on completion it SHALL capture IR and go to DECODE.
REQ-017 In DECODE the block SHALL read rs1/rs2 into operand registers and generate the immediate (I, S or B format, sign-extended to XLEN); an unsupported opcode or funct SHALL go to TRAP.
REQ-018 Supported instructions SHALL be add, sub, and, or, addi, lw, sw and beq; slt SHALL be supported per REQ-033.
REQ-019 In EXEC, R-type and addi SHALL go to WB; lw and sw SHALL compute rs1+imm and go to MEM.
REQ-020 In EXEC, beq SHALL load pc+imm into pc if rs1==rs2, else pc+4, then pulse retire and go to FETCH.
REQ-021 In MEM the block SHALL drive mem_req=1, mem_we=1 for sw with mem_wdata=rs2, and mem_we=0 for lw; it SHALL hold until mem_ready.
REQ-022 On MEM completion, sw SHALL pulse retire, set pc+=4 and go to FETCH; lw SHALL capture mem_rdata into MDR and go to WB.
REQ-023 WB SHALL assert wb_valid for one cycle, with writedata = ALU result, or MDR when memtoreg; it SHALL set pc+=4, pulse retire and go to FETCH.
REQ-024 The instruction latency with mem_ready tied to 1 SHALL be: beq 3 cycles, R/I-type and sw 4 cycles, lw 5 cycles.
REQ-025 x0 SHALL read as zero and writes to x0 SHALL be discarded; wb_valid SHALL still pulse with wb_rd=0.
REQ-026 Arithmetic SHALL be modulo 2^XLEN; no overflow detection.
REQ-027 A branch target that is not word-aligned SHALL have its low 2 bits forced to 0.
REQ-028 TRAP SHALL be terminal until reset: trap=1, mem_req=0, no retire.
REQ-029 Outside FETCH and MEM, mem_req SHALL be 0, and mem_addr/mem_wdata are don't-care.

Reset
REQ-030 With rst=0 at a rising clk edge, the block SHALL set pc=RESET_PC and state=FETCH, and drive trap, wb_valid, retire and mem_we to 0.
REQ-031 Reset SHALL abort any in-flight transaction (including a stalled FETCH or MEM) with no write-back.
REQ-032 Register file contents other than x0 SHALL NOT be reset.

Configuration
REQ-033 Macro RISCV_SLT_EN, when defined, SHALL enable slt (funct3=010, funct7=0), writing 1 if rs1<rs2 signed, else 0; when undefined, that encoding SHALL go to TRAP.

Structure
REQ-034 Package rv_pkg SHALL hold the opcode constants, the state enum, and the ALU-op enum (ADD, SUB, AND, OR, SLT).
REQ-035 The register file SHALL be a sub-module rv_regfile, parametrised by XLEN, with 2 combinational read ports and 1 synchronous write port.

Verification
REQ-036 Reset scenario: hold rst=0 for 2 cycles then release; the first cycle SHALL show mem_req=1, mem_addr=RESET_PC.
REQ-037 R/I-type scenario: with mem_ready=1, execute 0x00500113 (addi x2,x0,5) then 0x00210233 (add x4,x2,x2); write-backs SHALL be rd=2 value 5, then rd=4 value 10, with retire 4 cycles apart.
REQ-038 Load/store scenario: after x2=5, execute 0x00202423 (sw x2,8(x0)) -> mem_we=1, addr=8, wdata=5; then 0x00802183 (lw x3,8(x0)) with rdata=5 -> wb rd=3 value 5, 5 cycles.
REQ-039 Branch scenario: 0x00000463 (beq x0,x0,8) at pc=0x10 SHALL fetch next from 0x18; with rs1≠rs2 it SHALL fetch next from 0x14.
REQ-040 Stall scenario: mem_ready=0 for 3 cycles in FETCH SHALL hold addr stable with no retire; fetching 0xFFFFFFFF SHALL set trap=1 and mem_req=0 until reset.
REQ-041 SLT scenario: with x2=5 and x4=10, 0x004122B3 (slt x5,x2,x4) SHALL write x5=1 with RISCV_SLT_EN and SHALL trap without it.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the multicycle RV32I subset core: opcodes, FSM states, ALU ops.
// Latency: none (declarations and pure decode functions only).
// Backpressure: n/a. RISCV_SLT_EN adds slt to the legal-instruction set.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  // True when the encoding belongs to the implemented subset.
  function automatic logic insn_legal(input logic [31:0] insn);
    logic [9:0] fkey;
    logic       legal;
    fkey  = {insn[31:25], insn[14:12]};
    legal = 1'b0;
    case (insn[6:0])
      OPC_OP: begin
        case (fkey)
          {F7_BASE, F3_ADD},
          {F7_ALT,  F3_ADD},
          {F7_BASE, F3_AND},
          {F7_BASE, F3_OR}:  legal = 1'b1;
`ifdef RISCV_SLT_EN
          {F7_BASE, F3_SLT}: legal = 1'b1;
`endif
          default:           legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: legal = (insn[14:12] == F3_ADD);
      OPC_LOAD:   legal = (insn[14:12] == F3_W);
      OPC_STORE:  legal = (insn[14:12] == F3_W);
      OPC_BRANCH: legal = (insn[14:12] == F3_BEQ);
      default:    legal = 1'b0;
    endcase
    return legal;
  endfunction

  // ALU operation for an instruction; everything but R-type adds (addi, address calc).
  function automatic alu_op_t alu_op_of(input logic [31:0] insn);
    alu_op_t op;
    op = ALU_ADD;
    if (insn[6:0] == OPC_OP) begin
      case (insn[14:12])
        F3_ADD:  op = insn[30] ? ALU_SUB : ALU_ADD;
        F3_SLT:  op = ALU_SLT;
        F3_OR:   op = ALU_OR;
        F3_AND:  op = ALU_AND;
        default: op = ALU_ADD;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32-entry integer register file, x0 hard-wired to zero.
// Latency: reads combinational, write visible the cycle after the write edge.
// Backpressure: none; a write is accepted every cycle it is enabled.
module rv_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic [4:0]      ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  // Entry 0 is never written; reads of x0 are masked below.
  logic [XLEN-1:0] regs [0:31];

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

  // Synchronous write port; writes aimed at x0 are dropped.
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

endmodule

// File: rtl/multicycle_riscv.sv
// Multicycle core for add/sub/and/or/addi/lw/sw/beq (+slt when RISCV_SLT_EN is defined).
// Latency: beq 3, R/I-type and sw 4, lw 5 cycles with zero-wait memory.
// Backpressure: FETCH and MEM hold their request until mem_ready; illegal opcodes park in TRAP.
module multicycle_riscv
  import rv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] writedata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            retire,
  output logic            trap
);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [31:0]     ir;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] mdr;

  logic [6:0]      opcode;
  logic            is_rtype;
  logic            is_load;
  logic            is_store;
  logic            is_branch;
  logic [XLEN-1:0] imm_gen;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;

  assign opcode    = ir[6:0];
  assign is_rtype  = (opcode == OPC_OP);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);

  assign pc_plus4  = pc + XLEN'(4);
  assign br_target = pc + imm;
  assign alu_b     = is_rtype ? opb : imm;

  rv_regfile #(
    .XLEN (XLEN)
  ) u_regfile (
    .clk (clk),
    .ra1 (ir[19:15]),
    .rd1 (rf_rd1),
    .ra2 (ir[24:20]),
    .rd2 (rf_rd2),
    .we  (wb_valid),
    .wa  (ir[11:7]),
    .wd  (writedata)
  );

  // Immediate extraction: I format by default, S for stores, B for branches.
  always_comb begin
    imm_gen = {{(XLEN-12){ir[31]}}, ir[31:20]};
    case (opcode)
      OPC_STORE:  imm_gen = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH: imm_gen = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      default:    ;
    endcase
  end

  // ALU; wraps modulo 2^XLEN, slt is a signed compare.
  always_comb begin
    alu_out = opa + alu_b;
    case (alu_op_of(ir))
      ALU_ADD: alu_out = opa + alu_b;
      ALU_SUB: alu_out = opa - alu_b;
      ALU_AND: alu_out = opa & alu_b;
      ALU_OR:  alu_out = opa | alu_b;
      ALU_SLT: alu_out = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(alu_b))};
      default: alu_out = opa + alu_b;
    endcase
  end

  // Bus and status outputs decode from state; rst gates them so a reset
  // cycle can never complete a memory transaction or a write-back.
  always_comb begin
    mem_req   = rst && ((state == ST_FETCH) || (state == ST_MEM));
    mem_we    = rst && (state == ST_MEM) && is_store;
    mem_addr  = (state == ST_FETCH) ? pc : {alu_res[XLEN-1:2], 2'b00};
    mem_wdata = opb;
    wb_valid  = rst && (state == ST_WB);
    wb_rd     = ir[11:7];
    writedata = is_load ? mdr : alu_res;
    retire    = rst && (((state == ST_EXEC) && is_branch) ||
                        ((state == ST_MEM) && is_store && mem_ready) ||
                        (state == ST_WB));
    trap      = (state == ST_TRAP);
  end

  // Control: state sequencing and PC update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
    end else begin
      case (state)
        ST_FETCH: begin
          if (mem_ready) begin
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state <= insn_legal(ir) ? ST_EXEC : ST_TRAP;
        end
        ST_EXEC: begin
          if (is_branch) begin
            // Targets are word-aligned by truncation.
            pc    <= (opa == opb) ? {br_target[XLEN-1:2], 2'b00} : pc_plus4;
            state <= ST_FETCH;
          end else if (is_load || is_store) begin
            state <= ST_MEM;
          end else begin
            state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (is_store) begin
              pc    <= pc_plus4;
              state <= ST_FETCH;
            end else begin
              state <= ST_WB;
            end
          end
        end
        ST_WB: begin
          pc    <= pc_plus4;
          state <= ST_FETCH;
        end
        ST_TRAP: begin
          state <= ST_TRAP;
        end
        default: begin
          state <= ST_TRAP;
        end
      endcase
    end
  end

  // Datapath registers; contents are meaningless after reset, so no reset term.
  always_ff @(posedge clk) begin
    case (state)
      ST_FETCH: begin
        if (mem_ready) begin
          ir <= mem_rdata[31:0];
        end
      end
      ST_DECODE: begin
        opa <= rf_rd1;
        opb <= rf_rd2;
        imm <= imm_gen;
      end
      ST_EXEC: begin
        alu_res <= alu_out;
      end
      ST_MEM: begin
        if (mem_ready && !is_store) begin
          mdr <= mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_riscv.sv
// Directed bench: instruction table with expected write-back/store/branch results and
// latencies, plus hand sequences for reset, fetch stall, MEM-stall abort and trap.
module tb_multicycle_riscv;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] writedata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        retire;
  logic        trap;

  logic [31:0] mem [0:63];
  int          tests = 0;
  int          fails = 0;

  typedef enum int {K_WB, K_ST, K_BR} kind_e;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    kind_e       kind;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] addr;
    int          lat;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] trap_pc;

  multicycle_riscv #(
    .XLEN     (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .writedata (writedata),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .retire    (retire),
    .trap      (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; the memory model commits a store at the edge when the
  // request completes. Returns at negedge+1 with outputs settled.
  task automatic tick();
    logic        do_wr;
    logic [31:0] wa;
    logic [31:0] wd;
    #1;
    do_wr = mem_req && mem_we && mem_ready;
    wa    = mem_addr;
    wd    = mem_wdata;
    @(posedge clk);
    if (do_wr) mem[wa[7:2]] = wd;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_retire(output int cyc);
    cyc = 0;
    while (cyc < 40) begin
      tick();
      cyc++;
      if (retire === 1'b1) break;
    end
    check("retire_seen", retire, 1'b1);
  endtask

  initial begin
    int cyc;
    rst       = 1'b0;
    mem_ready = 1'b1;

    //           pc      insn          kind  rd     value          addr   lat
    vecs.push_back('{32'h00, 32'h00500113, K_WB, 5'd2,  32'd5,         32'h0, 4}); // addi x2,x0,5
    vecs.push_back('{32'h04, 32'h00210233, K_WB, 5'd4,  32'd10,        32'h0, 4}); // add x4,x2,x2
    vecs.push_back('{32'h08, 32'h00202423, K_ST, 5'd0,  32'd5,         32'h8, 4}); // sw x2,8(x0)
    vecs.push_back('{32'h0C, 32'h00802183, K_WB, 5'd3,  32'd5,         32'h0, 5}); // lw x3,8(x0)
    vecs.push_back('{32'h10, 32'h00000463, K_BR, 5'd0,  32'd0,         32'h0, 3}); // beq x0,x0,8 taken
    vecs.push_back('{32'h18, 32'h00010463, K_BR, 5'd0,  32'd0,         32'h0, 3}); // beq x2,x0,8 not taken
    vecs.push_back('{32'h1C, 32'h404103B3, K_WB, 5'd7,  32'hFFFFFFFB,  32'h0, 4}); // sub x7,x2,x4
    vecs.push_back('{32'h20, 32'h00417433, K_WB, 5'd8,  32'd0,         32'h0, 4}); // and x8,x2,x4
    vecs.push_back('{32'h24, 32'h004164B3, K_WB, 5'd9,  32'd15,        32'h0, 4}); // or x9,x2,x4
    vecs.push_back('{32'h28, 32'h00210033, K_WB, 5'd0,  32'd10,        32'h0, 4}); // add x0,x2,x2
    vecs.push_back('{32'h2C, 32'h00200333, K_WB, 5'd6,  32'd5,         32'h0, 4}); // add x6,x0,x2
    vecs.push_back('{32'h30, 32'hFFF00513, K_WB, 5'd10, 32'hFFFFFFFF,  32'h0, 4}); // addi x10,x0,-1
    vecs.push_back('{32'h34, 32'h00000563, K_BR, 5'd0,  32'd0,         32'h0, 3}); // beq +10 -> 0x3C
`ifdef RISCV_SLT_EN
    vecs.push_back('{32'h3C, 32'h004122B3, K_WB, 5'd5,  32'd1,         32'h0, 4}); // slt x5,x2,x4
    trap_pc = 32'h40;
`else
    trap_pc = 32'h3C;
`endif

    for (int i = 0; i < 64; i++) mem[i] = 32'hFFFFFFFF;
    for (int i = 0; i < vecs.size(); i++) mem[vecs[i].pc[7:2]] = vecs[i].insn;
    mem[15] = 32'h004122B3;  // slt at 0x3C: legal or trapping depending on build

    // Reset held for two edges.
    tick();
    tick();
    check("rst_trap", trap, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_retire", retire, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    rst = 1'b1;
    #1;
    check("first_req", mem_req, 1'b1);
    check("first_addr", mem_addr, RESET_PC);

    // addi runs unstalled, then the fetch of add stalls three cycles.
    wait_retire(cyc);
    check("pre_stall_lat", cyc + 1, 4);
    check("pre_stall_rd", wb_rd, 5'd2);
    check("pre_stall_val", writedata, 32'd5);
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall_addr[%0d]", k), mem_addr, 32'h4);
      check($sformatf("stall_req[%0d]", k), mem_req, 1'b1);
      check($sformatf("stall_retire[%0d]", k), retire, 1'b0);
      tick();
    end
    check("stall_hold_addr", mem_addr, 32'h4);
    mem_ready = 1'b1;
    wait_retire(cyc);
    check("stall_lat", cyc + 4, 7);
    check("stall_rd", wb_rd, 5'd4);
    check("stall_val", writedata, 32'd10);

    // sw stalls in MEM, then reset aborts it: no store, no retire.
    tick();
    for (int k = 0; k < 10 && mem_we !== 1'b1; k++) tick();
    check("memstall_we", mem_we, 1'b1);
    mem_ready = 1'b0;
    #1;
    check("memstall_retire", retire, 1'b0);
    check("memstall_addr", mem_addr, 32'h8);
    tick();
    check("memhold_we", mem_we, 1'b1);
    check("memhold_retire", retire, 1'b0);
    check("memhold_wdata", mem_wdata, 32'd5);
    rst       = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("abort_req", mem_req, 1'b0);
    check("abort_retire", retire, 1'b0);
    tick();
    check("abort_no_store", mem[2], 32'h00202423);
    rst = 1'b1;
    #1;
    check("restart_req", mem_req, 1'b1);
    check("restart_addr", mem_addr, RESET_PC);

    // Program table; each iteration starts at that instruction's fetch cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("fetch_addr[%0d]", i), mem_addr, vecs[i].pc);
      check($sformatf("fetch_rd[%0d]", i), {mem_req, mem_we}, 2'b10);
      wait_retire(cyc);
      check($sformatf("latency[%0d]", i), cyc + 1, vecs[i].lat);
      case (vecs[i].kind)
        K_WB: begin
          check($sformatf("wb_valid[%0d]", i), wb_valid, 1'b1);
          check($sformatf("wb_rd[%0d]", i), wb_rd, vecs[i].rd);
          check($sformatf("wb_data[%0d]", i), writedata, vecs[i].val);
        end
        K_ST: begin
          check($sformatf("st_we[%0d]", i), mem_we, 1'b1);
          check($sformatf("st_addr[%0d]", i), mem_addr, vecs[i].addr);
          check($sformatf("st_data[%0d]", i), mem_wdata, vecs[i].val);
        end
        default: begin
          check($sformatf("br_nowb[%0d]", i), {wb_valid, mem_req}, 2'b00);
        end
      endcase
      tick();
    end

    // Illegal fetch: trap is terminal until reset.
    check("trap_fetch_addr", mem_addr, trap_pc);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("trap_flag[%0d]", k), trap, 1'b1);
      check($sformatf("trap_quiet[%0d]", k), {mem_req, retire, wb_valid}, 3'b000);
      tick();
    end
    rst = 1'b0;
    tick();
    check("trap_cleared", trap, 1'b0);
    rst = 1'b1;
    #1;
    check("post_trap_req", mem_req, 1'b1);
    check("post_trap_addr", mem_addr, RESET_PC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
